reg_access_ctrl: RTL

Command sequencer for the 4-entry, 9-bit operand register file: it accepts WRITE / READ / MOVE commands over a valid/ready handshake and drives the register file's write port (`reg_num`, `op`) and read port (`reg_sel`, `reg_val`). It sits between the matrix-op control FSM and the register file. It returns operand pairs on a valid/ready response channel.

---
 rtl/reg_access_pkg.sv | 31 +++
 rtl/reg_access_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reg_access_pkg.sv
// Shared types and defaults for the operand register file command sequencer.
package reg_access_pkg;

    localparam int DATA_W   = 9;
    localparam int IDX_W    = 3;
    localparam int NUM_REGS = 4;

    typedef enum logic [1:0] {
        WRITE = 2'd0,
        READ  = 2'd1,
        MOVE  = 2'd2,
        RSVD  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        SEL_A,
        SEL_B,
        CAP_B,
        MV_CAP,
        MV_WR,
        RESP
    } state_e;

    // Register indices are 1-based; 0 means "no access".
    function automatic logic idx_ok(input int idx);
        return (idx >= 1) && (idx <= NUM_REGS);
    endfunction

endpackage

// File: rtl/reg_access_ctrl.sv
// WRITE/READ/MOVE sequencer in front of the 4-entry operand register file.
// Define REG_ACCESS_BOUNDS_CHK_EN to reject commands that use indices outside 1..NUM_REGS.
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int DATA_W = reg_access_pkg::DATA_W,
    parameter int IDX_W  = reg_access_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_dst,
    input  logic [IDX_W-1:0]  cmd_src_a,
    input  logic [IDX_W-1:0]  cmd_src_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [IDX_W-1:0]  reg_num,
    output logic [DATA_W-1:0] op,
    output logic [IDX_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_val,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic              err
);

    state_e              state_q;
    cmd_op_e             kind_q;
    logic [IDX_W-1:0]    dst_q, src_b_q;
    logic [IDX_W-1:0]    reg_num_q, reg_sel_q;
    logic [DATA_W-1:0]   wdata_q, rsp_a_q, rsp_b_q;
    logic                rsp_valid_q, err_q;

    cmd_op_e cmd_kind;
    logic    idx_bad;

    assign cmd_kind = cmd_op_e'(cmd_op);

`ifdef REG_ACCESS_BOUNDS_CHK_EN
    always_comb begin
        idx_bad = 1'b0;
        case (cmd_kind)
            WRITE:   idx_bad = !idx_ok(int'(cmd_dst));
            READ:    idx_bad = !idx_ok(int'(cmd_src_a)) || !idx_ok(int'(cmd_src_b));
            MOVE:    idx_bad = !idx_ok(int'(cmd_src_a)) || !idx_ok(int'(cmd_dst));
            default: idx_bad = 1'b0;
        endcase
    end
`else
    assign idx_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            kind_q      <= WRITE;
            dst_q       <= '0;
            src_b_q     <= '0;
            reg_num_q   <= '0;
            reg_sel_q   <= '0;
            wdata_q     <= '0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        kind_q  <= cmd_kind;
                        dst_q   <= cmd_dst;
                        src_b_q <= cmd_src_b;
                        // Rejected commands are consumed without touching the register file.
                        if (cmd_kind == RSVD || idx_bad) begin
                            err_q <= 1'b1;
                        end else if (cmd_kind == WRITE) begin
                            reg_num_q <= cmd_dst;
                            wdata_q   <= cmd_data;
                            state_q   <= WR;
                        end else begin
                            reg_sel_q <= cmd_src_a;
                            state_q   <= SEL_A;
                        end
                    end
                end
                WR: begin
                    reg_num_q <= '0;
                    state_q   <= IDLE;
                end
                SEL_A: begin
                    if (kind_q == MOVE) begin
                        reg_sel_q <= '0;
                        state_q   <= MV_CAP;
                    end else begin
                        reg_sel_q <= src_b_q;
                        state_q   <= SEL_B;
                    end
                end
                SEL_B: begin
                    rsp_a_q   <= reg_val;
                    reg_sel_q <= '0;
                    state_q   <= CAP_B;
                end
                CAP_B: begin
                    rsp_b_q     <= reg_val;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                MV_CAP: begin
                    wdata_q   <= reg_val;
                    reg_num_q <= dst_q;
                    state_q   <= MV_WR;
                end
                MV_WR: begin
                    reg_num_q <= '0;
                    state_q   <= IDLE;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign reg_num   = reg_num_q;
    assign op        = wdata_q;
    assign reg_sel   = reg_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;
    assign err       = err_q;

endmodule
